// File: rtl/pe_sched_pkg.sv
// Shared types and helpers for the PE array phase scheduler.
//   state_e  : scheduler phase encoding
//   id_w()   : width of the X-bus destination ID for a given array shape
//   out_len(): output rows produced per column for filter length S, ifmap length W
package pe_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLdFltr,
        StLdIfmap,
        StCompute,
        StDrain,
        StDone
    } state_e;

    // Diagonal IDs run 0..NUM_ROW+NUM_COL-2; never let the width collapse to zero.
    function automatic int unsigned id_w(input int unsigned num_row, input int unsigned num_col);
        if (num_row + num_col - 1 > 1) begin
            return $clog2(num_row + num_col - 1);
        end
        return 1;
    endfunction

    function automatic int unsigned out_len(input int unsigned s, input int unsigned w);
        return w - s + 1;
    endfunction

endpackage

// File: rtl/sched_cnt2d.sv
// Nested word/row counter. The word count advances on en_i and wraps at
// word_len_i-1, at which point the row count advances; the row count wraps at
// row_len_i-1, so after a full pass the counter is back at (0,0).
//   clk, rst    : clock, async active-high reset
//   clr_i       : synchronous clear to (0,0)
//   en_i        : advance by one word
//   word_len_i  : words per row (>= 1)
//   row_len_i   : rows per pass (>= 1)
//   row_o       : current row index
//   last_o      : current position is the final word of the final row
module sched_cnt2d #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] word_len_i,
    input  logic [CNT_W-1:0] row_len_i,
    output logic [CNT_W-1:0] row_o,
    output logic             last_o
);

    logic [CNT_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             word_last, row_last;

    assign word_last = (word_q == word_len_i - CNT_W'(1));
    assign row_last  = (row_q == row_len_i - CNT_W'(1));

    always_comb begin
        word_d = word_q;
        row_d  = row_q;
        if (clr_i) begin
            word_d = '0;
            row_d  = '0;
        end else if (en_i) begin
            if (word_last) begin
                word_d = '0;
                row_d  = row_last ? '0 : row_q + CNT_W'(1);
            end else begin
                word_d = word_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            row_q  <= '0;
        end else begin
            word_q <= word_d;
            row_q  <= row_d;
        end
    end

    assign row_o  = row_q;
    assign last_o = word_last && row_last;

endmodule

// File: rtl/pe_array_sched.sv
// Phase scheduler for the row-stationary PE array. On an accepted start it
// streams NUM_ROW filter rows and NUM_ROW+NUM_COL-1 ifmap diagonals from the
// GLB onto the X-buses, enables compute for S*(W-S+1) cycles, drains
// NUM_COL*(W-S+1) psums back to the GLB and pulses done.
//   clk, rst                     : clock, async active-high reset
//   start, cfg_fltr_len (S),
//   cfg_ifmap_len (W)            : pass request and configuration
//   busy, done, cfg_err, flush   : status / control pulses
//   in_valid/in_ready/in_data    : GLB input stream
//   bus_valid/bus_ready/bus_is_fltr/bus_id/bus_data : row X-bus
//   compute_en                   : PE MAC enable
//   psum_valid/psum_ready/psum_data : array psum stream
//   out_valid/out_ready/out_data : GLB psum write stream
module pe_array_sched
    import pe_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_ROW    = 3,
    parameter int unsigned NUM_COL    = 3,
    parameter int unsigned CNT_W      = 8,
    localparam int unsigned ID_W      = id_w(NUM_ROW, NUM_COL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      cfg_fltr_len,
    input  logic [CNT_W-1:0]      cfg_ifmap_len,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  bus_is_fltr,
    output logic [ID_W-1:0]       bus_id,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  compute_en,
    input  logic                  psum_valid,
    output logic                  psum_ready,
    input  logic [DATA_WIDTH-1:0] psum_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [CNT_W-1:0] FltrRows  = CNT_W'(NUM_ROW);
    localparam logic [CNT_W-1:0] IfmapDiag = CNT_W'(NUM_ROW + NUM_COL - 1);
    localparam logic [CNT_W-1:0] DrainCols = CNT_W'(NUM_COL);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   w_q, w_d;
    logic [2*CNT_W-1:0] cmp_q, cmp_d;
    logic               flush_q, flush_d;
    logic               err_q, err_d;

    logic               fltr_st, load_st, drain_st;
    logic               load_xfer, drain_xfer;
    logic               cfg_ok, accept;
    logic [CNT_W-1:0]   ol;
    logic [2*CNT_W-1:0] cmp_total;
    logic [CNT_W-1:0]   load_row, drain_row;
    logic               load_last, drain_last;
    logic               unused_drain_row;

    assign fltr_st    = (state_q == StLdFltr);
    assign load_st    = fltr_st || (state_q == StLdIfmap);
    assign drain_st   = (state_q == StDrain);
    assign load_xfer  = load_st && in_valid && bus_ready;
    assign drain_xfer = drain_st && psum_valid && out_ready;

    assign cfg_ok = (cfg_fltr_len != '0) && (cfg_ifmap_len >= cfg_fltr_len);
    assign accept = (state_q == StIdle) && start && cfg_ok;

    // W >= S >= 1, so W-S+1 lies in 1..W and fits CNT_W bits.
    assign ol        = CNT_W'(out_len(32'(s_q), 32'(w_q)));
    assign cmp_total = {{CNT_W{1'b0}}, s_q} * {{CNT_W{1'b0}}, ol};

    // One counter serves both load phases: it wraps to (0,0) on the final
    // filter word, so the ifmap phase starts clean without an explicit clear.
    sched_cnt2d #(
        .CNT_W(CNT_W)
    ) u_load_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .en_i       (load_xfer),
        .word_len_i (fltr_st ? s_q : w_q),
        .row_len_i  (fltr_st ? FltrRows : IfmapDiag),
        .row_o      (load_row),
        .last_o     (load_last)
    );

    sched_cnt2d #(
        .CNT_W(CNT_W)
    ) u_drain_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .en_i       (drain_xfer),
        .word_len_i (ol),
        .row_len_i  (DrainCols),
        .row_o      (drain_row),
        .last_o     (drain_last)
    );

    assign unused_drain_row = ^drain_row;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        w_d     = w_q;
        cmp_d   = cmp_q;
        flush_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        s_d     = cfg_fltr_len;
                        w_d     = cfg_ifmap_len;
                        cmp_d   = '0;
                        flush_d = 1'b1;
                        state_d = StLdFltr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLdFltr: begin
                if (load_xfer && load_last) state_d = StLdIfmap;
            end
            StLdIfmap: begin
                if (load_xfer && load_last) state_d = StCompute;
            end
            StCompute: begin
                if (cmp_q == cmp_total - 1'b1) begin
                    cmp_d   = '0;
                    state_d = StDrain;
                end else begin
                    cmp_d = cmp_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_xfer && drain_last) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            w_q     <= '0;
            cmp_q   <= '0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            w_q     <= w_d;
            cmp_q   <= cmp_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    // Streams pass straight through; data is gated so idle buses read zero.
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign flush       = flush_q;
    assign cfg_err     = err_q;
    assign bus_valid   = load_st && in_valid;
    assign in_ready    = load_st && bus_ready;
    assign bus_data    = load_st ? in_data : '0;
    assign bus_is_fltr = fltr_st;
    assign bus_id      = load_st ? ID_W'(load_row) : '0;
    assign compute_en  = (state_q == StCompute);
    assign out_valid   = drain_st && psum_valid;
    assign psum_ready  = drain_st && out_ready;
    assign out_data    = drain_st ? psum_data : '0;

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed bench for pe_array_sched: reset checks, a mid-phase reset, then a
// table of passes (nominal, edge, stalled, illegal, start held high).
module tb_pe_array_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_fltr_len, cfg_ifmap_len;
    logic        busy, done, cfg_err, flush;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        bus_valid, bus_ready, bus_is_fltr;
    logic [2:0]  bus_id;
    logic [15:0] bus_data;
    logic        compute_en;
    logic        psum_valid, psum_ready;
    logic [15:0] psum_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pe_array_sched dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_fltr_len  (cfg_fltr_len),
        .cfg_ifmap_len (cfg_ifmap_len),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .bus_valid     (bus_valid),
        .bus_ready     (bus_ready),
        .bus_is_fltr   (bus_is_fltr),
        .bus_id        (bus_id),
        .bus_data      (bus_data),
        .compute_en    (compute_en),
        .psum_valid    (psum_valid),
        .psum_ready    (psum_ready),
        .psum_data     (psum_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data)
    );

    typedef struct {
        int s;
        int w;
        bit legal;
        bit stall;
        bit hold;
        int nf;    // filter words
        int ni;    // ifmap words
        int nc;    // compute cycles
        int no;    // psums drained
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_bus_valid"}, int'(bus_valid), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_compute_en"}, int'(compute_en), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_psum_ready"}, int'(psum_ready), 0);
        chk({tag, "_flush"}, int'(flush), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    endtask

    // Called at posedge+1 with the DUT idle.
    task automatic run_vec(input int idx, input vec_t v);
        int fi = 0, ii = 0, oi = 0, comp = 0, dn = 0, fl = 0, er = 0, bsy = 0, cyc = 0;
        int src = 0, psrc = 0;
        bit fin = 1'b0;
        string t;
        t = $sformatf("v%0d", idx);
        cfg_fltr_len  = 8'(v.s);
        cfg_ifmap_len = 8'(v.w);
        start = 1'b1;
        while (!fin) begin
            if (v.stall) begin
                in_valid   = 1'($urandom_range(0, 1));
                bus_ready  = 1'($urandom_range(0, 1));
                psum_valid = 1'($urandom_range(0, 1));
                out_ready  = 1'($urandom_range(0, 1));
            end else begin
                in_valid   = 1'b1;
                bus_ready  = 1'b1;
                psum_valid = 1'b1;
                out_ready  = 1'b1;
            end
            in_data   = 16'h1000 + 16'(src);
            psum_data = 16'hA000 + 16'(psrc);
            @(negedge clk);
            if (bus_valid && bus_ready) begin
                if (bus_is_fltr) begin
                    chk({t, "_fltr_data"}, int'(bus_data), 'h1000 + fi);
                    chk({t, "_fltr_id"}, int'(bus_id), fi / v.s);
                    fi++;
                end else begin
                    chk({t, "_ifmap_data"}, int'(bus_data), 'h1000 + 3 * v.s + ii);
                    chk({t, "_ifmap_id"}, int'(bus_id), ii / v.w);
                    ii++;
                end
            end
            if (in_valid && in_ready) src++;
            if (psum_valid && psum_ready) psrc++;
            if (out_valid && out_ready) begin
                chk({t, "_psum_data"}, int'(out_data), 'hA000 + oi);
                oi++;
            end
            if (compute_en) comp++;
            if (done) dn++;
            if (flush) fl++;
            if (cfg_err) er++;
            if (busy) bsy = 1;
            cyc++;
            if (done || (!v.legal && cyc >= 6)) fin = 1'b1;
            if (cyc >= 3000) begin
                chk({t, "_timeout"}, cyc, 0);
                fin = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!v.hold) start = 1'b0;
        end
        chk({t, "_n_fltr"}, fi, v.nf);
        chk({t, "_n_ifmap"}, ii, v.ni);
        chk({t, "_n_compute"}, comp, v.nc);
        chk({t, "_n_psum"}, oi, v.no);
        chk({t, "_n_done"}, dn, v.legal ? 1 : 0);
        chk({t, "_n_flush"}, fl, v.legal ? 1 : 0);
        chk({t, "_n_cfg_err"}, er, v.legal ? 0 : 1);
        chk({t, "_busy_seen"}, bsy, v.legal ? 1 : 0);
        @(negedge clk);
        chk({t, "_idle_busy"}, int'(busy), 0);
        chk({t, "_idle_done"}, int'(done), 0);
        @(posedge clk);
        #1;
        if (v.hold) begin
            // start still high: a fresh pass begins only now, from IDLE
            @(negedge clk);
            chk({t, "_restart_busy"}, int'(busy), 1);
            chk({t, "_restart_flush"}, int'(flush), 1);
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit seen;
        vecs[0] = '{s: 3, w: 5, legal: 1, stall: 0, hold: 0, nf: 9, ni: 25, nc: 9, no: 9};
        vecs[1] = '{s: 1, w: 1, legal: 1, stall: 0, hold: 0, nf: 3, ni: 5,  nc: 1, no: 3};
        vecs[2] = '{s: 2, w: 4, legal: 1, stall: 0, hold: 0, nf: 6, ni: 20, nc: 6, no: 9};
        vecs[3] = '{s: 3, w: 5, legal: 1, stall: 1, hold: 0, nf: 9, ni: 25, nc: 9, no: 9};
        vecs[4] = '{s: 0, w: 5, legal: 0, stall: 0, hold: 0, nf: 0, ni: 0,  nc: 0, no: 0};
        vecs[5] = '{s: 4, w: 3, legal: 0, stall: 0, hold: 0, nf: 0, ni: 0,  nc: 0, no: 0};
        vecs[6] = '{s: 3, w: 5, legal: 1, stall: 0, hold: 1, nf: 9, ni: 25, nc: 9, no: 9};

        rst = 1'b1;
        start = 1'b0;
        cfg_fltr_len = '0;
        cfg_ifmap_len = '0;
        in_valid = 1'b0;
        bus_ready = 1'b0;
        in_data = '0;
        psum_valid = 1'b0;
        psum_data = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset while streaming ifmap words.
        cfg_fltr_len = 8'd3;
        cfg_ifmap_len = 8'd5;
        start = 1'b1;
        in_valid = 1'b1;
        bus_ready = 1'b1;
        in_data = 16'h1234;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bus_valid && !bus_is_fltr) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        chk("midrst_reach_ifmap", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("midrst");
        chk("midrst_bus_id", int'(bus_id), 0);
        chk("midrst_bus_data", int'(bus_data), 0);
        start = 1'b0;
        in_valid = 1'b0;
        bus_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_array_sched.md
Name: pe_array_sched

Overview:
Phase scheduler for the row-stationary PE array. Its work is driven by a start pulse and a latched configuration.
- It streams filter rows and ifmap rows from the global buffer onto the row X-buses, tagged with destination IDs.
- It then enables compute for a counted number of cycles.
- Finally it drains the column partial sums back to the global buffer and pulses done.
It sits between the GLB stream ports and the PE array's bus controllers.

Parameters:
DATA_WIDTH, 16, word width of filter, ifmap and psum data
NUM_ROW, 3, PE array rows (= filter rows)
NUM_COL, 3, PE array columns (= output rows)
CNT_W, 8, width of configuration length fields

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin a pass; sampled only in IDLE
cfg_fltr_len  in  CNT_W  words per filter row (S)
cfg_ifmap_len  in  CNT_W  words per ifmap row (W)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of pass
cfg_err  out  1  one-cycle pulse on rejected start
flush  out  1  one-cycle pulse clearing PE scratchpads
in_valid  in  1  GLB input stream valid
in_ready  out  1  GLB input stream ready
in_data  in  DATA_WIDTH  GLB input word
bus_valid  out  1  X-bus word valid
bus_ready  in  1  X-bus accept
bus_is_fltr  out  1  1 = filter word, 0 = ifmap word
bus_id  out  $clog2(NUM_ROW+NUM_COL-1)  filter: row index; ifmap: diagonal index r+c
bus_data  out  DATA_WIDTH  X-bus word
compute_en  out  1  PE MAC enable
psum_valid  in  1  array psum output valid
psum_ready  out  1  array psum accept
psum_data  in  DATA_WIDTH  array psum word
out_valid  out  1  GLB psum write valid
out_ready  in  1  GLB psum write accept
out_data  out  DATA_WIDTH  GLB psum word

Behaviour:
- Reset (async, any state): state=IDLE, all counters 0, every output 0.
- States: IDLE, LD_FLTR, LD_IFMAP, COMPUTE, DRAIN, DONE.
- IDLE, start=1:
  - Config is legal if S≥1 and W≥S. Latch S and W, pulse flush, go to LD_FLTR.
  - Illegal config: pulse cfg_err, stay IDLE.
- start while busy: ignored.
- LD_FLTR:
  - bus_valid=in_valid, in_ready=bus_ready, bus_data=in_data (combinational), bus_is_fltr=1, bus_id=row counter.
  - A transfer is in_valid&bus_ready. Each transfer advances the word counter; at S-1 the word counter wraps and the row counter advances.
  - After NUM_ROW*S transfers go to LD_IFMAP.
- LD_IFMAP:
  - Same handshake with bus_is_fltr=0 and bus_id=diagonal counter 0..NUM_ROW+NUM_COL-2, W words per diagonal.
  - After (NUM_ROW+NUM_COL-1)*W transfers go to COMPUTE.
- COMPUTE: compute_en=1 for exactly S*(W-S+1) consecutive cycles, then go to DRAIN. Counter width is 2*CNT_W, with no overflow.
- DRAIN:
  - out_valid=psum_valid, psum_ready=out_ready, out_data=psum_data.
  - After NUM_COL*(W-S+1) transfers go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Outside their own state, in_ready, bus_valid, psum_ready, out_valid and compute_en are 0. Stream stalls hold counters, and words are never dropped or duplicated.
- Last-word transfer: the state changes on the following edge. There is no bubble requirement beyond that one edge.

Decomposition:
- Package pe_sched_pkg holds:
  - state enum typedef;
  - ID_W = $clog2(NUM_ROW+NUM_COL-1), as a function of the parameters;
  - helper function out_len(S, W) = W-S+1.
- Sub-module: sched_cnt2d, a nested word/row counter with an enable and a last flag. It is instantiated for the load phases and for the drain.

Test Plan:
1. Reset mid-phase: rst during LD_IFMAP → immediate IDLE, all outputs 0. A following start with S=3, W=5 runs normally.
2. Nominal pass, NUM_ROW=NUM_COL=3, S=3, W=5, no stalls:
   - flush pulse on start;
   - 9 filter words with bus_id 0,0,0,1,1,1,2,2,2;
   - 25 ifmap words with bus_id 0..4, 5 each;
   - compute_en high exactly 9 cycles;
   - 9 psums forwarded unchanged;
   - single done pulse.
3. Random in_valid/bus_ready/out_ready backpressure at 50%, same config → identical word order and IDs, counts 9/25/9, no loss or duplicates.
4. Illegal configs S=0, and S=4 with W=3 → cfg_err pulse, busy stays 0, no bus activity.
5. start held high through a whole pass → exactly one pass runs, and a new pass begins only from IDLE after done.
6. Edge config S=W=1 → 3 filter words, 5 ifmap words, compute_en for 1 cycle, 3 psums drained.
